// File: rtl/pulse_meter_pkg.sv
// pulse_meter shared types: FSM state encoding and default sizes.
// Imported by pulse_meter and sync_edge_detect.
package pulse_meter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    HIGH = 2'd2,
    LOW  = 2'd3
  } pm_state_e;

  localparam int CNT_W_DEF       = 16;
  localparam int SYNC_STAGES_DEF = 2;

endpackage

// File: rtl/sync_edge_detect.sv
// Multi-flop synchroniser with rise/fall detection on the synced level.
// Reusable by any consumer of the pulse/trigger outputs.
module sync_edge_detect
  import pulse_meter_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic clock,
  input  logic reset_n,
  input  logic d,
  output logic s,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s_d;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
      s_d    <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d};
      s_d    <= sync_q[SYNC_STAGES-1];
    end
  end

  assign s    = sync_q[SYNC_STAGES-1];
  assign rise = s & ~s_d;
  assign fall = ~s & s_d;

endmodule

// File: rtl/pulse_meter.sv
// Pulse width/period meter with valid/ready result output.
// PULSE_METER_TIMEOUT_EN adds an idle watchdog and a sticky timeout port.
module pulse_meter
  import pulse_meter_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
`ifdef PULSE_METER_TIMEOUT_EN
  ,
  parameter int TIMEOUT     = 1000
`endif
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             signal_in,
  output logic [CNT_W-1:0] width_out,
  output logic [CNT_W-1:0] period_out,
  output logic             sat,
  output logic             meas_valid,
  input  logic             meas_ready,
  output logic [CNT_W-1:0] pulse_count,
  output logic             overrun
`ifdef PULSE_METER_TIMEOUT_EN
  ,
  output logic             timeout
`endif
);

  localparam logic [CNT_W-1:0] MAX = '1;

  logic             s_unused;
  logic             rise;
  logic             fall;
  pm_state_e        state;
  logic [CNT_W-1:0] width_cnt;
  logic [CNT_W-1:0] period_cnt;
  logic             sat_acc;
  logic             w_max;
  logic             p_max;
  logic             done;
  logic             accept;

  sync_edge_detect #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clock  (clock),
    .reset_n(reset_n),
    .d      (signal_in),
    .s      (s_unused),
    .rise   (rise),
    .fall   (fall)
  );

  assign w_max  = (width_cnt == MAX);
  assign p_max  = (period_cnt == MAX);
  assign done   = enable & (state == LOW) & rise;
  assign accept = meas_valid & meas_ready;

`ifdef PULSE_METER_TIMEOUT_EN
  localparam int IDLE_W = $clog2(TIMEOUT + 1);
  logic [IDLE_W-1:0] idle_cnt;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      width_cnt   <= '0;
      period_cnt  <= '0;
      sat_acc     <= 1'b0;
      width_out   <= '0;
      period_out  <= '0;
      sat         <= 1'b0;
      meas_valid  <= 1'b0;
      pulse_count <= '0;
      overrun     <= 1'b0;
`ifdef PULSE_METER_TIMEOUT_EN
      idle_cnt    <= '0;
      timeout     <= 1'b0;
`endif
    end else begin
      if (accept && !(pulse_count == MAX))
        pulse_count <= pulse_count + CNT_W'(1);

      // A completion may refill the slot in the same cycle it drains.
      if (done) begin
        if (!meas_valid || meas_ready) begin
          width_out  <= width_cnt;
          period_out <= period_cnt;
          sat        <= sat_acc;
          meas_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (accept) begin
        meas_valid <= 1'b0;
      end

      if (!enable) begin
        state      <= IDLE;
        width_cnt  <= '0;
        period_cnt <= '0;
        sat_acc    <= 1'b0;
      end else begin
        unique case (state)
          IDLE: state <= ARM;
          ARM: begin
            if (rise) begin
              width_cnt  <= CNT_W'(1);
              period_cnt <= CNT_W'(1);
              sat_acc    <= 1'b0;
              state      <= HIGH;
            end
          end
          HIGH: begin
            period_cnt <= period_cnt + CNT_W'(!p_max);
            if (fall) begin
              sat_acc <= sat_acc | p_max;
              state   <= LOW;
            end else begin
              width_cnt <= width_cnt + CNT_W'(!w_max);
              sat_acc   <= sat_acc | p_max | w_max;
            end
          end
          LOW: begin
            if (rise) begin
              width_cnt  <= CNT_W'(1);
              period_cnt <= CNT_W'(1);
              sat_acc    <= 1'b0;
              state      <= HIGH;
            end else begin
              period_cnt <= period_cnt + CNT_W'(!p_max);
              sat_acc    <= sat_acc | p_max;
            end
          end
          default: state <= IDLE;
        endcase
      end

`ifdef PULSE_METER_TIMEOUT_EN
      if (enable && (state == HIGH || state == LOW)) begin
        if (rise || fall) begin
          idle_cnt <= '0;
        end else if (idle_cnt == IDLE_W'(TIMEOUT - 1)) begin
          idle_cnt   <= '0;
          state      <= ARM;
          width_cnt  <= '0;
          period_cnt <= '0;
          sat_acc    <= 1'b0;
          timeout    <= 1'b1;
        end else begin
          idle_cnt <= idle_cnt + IDLE_W'(1);
        end
      end else begin
        idle_cnt <= '0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_pulse_meter.sv
// Scoreboard bench for pulse_meter: 16-bit main instance plus a 4-bit
// instance for saturation; driver pushes expectations, monitors pop.
module tb_pulse_meter;

  typedef struct {
    int w;
    int p;
    bit s;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic        en4 = 1'b0;
  logic        signal_in = 1'b0;
  logic        meas_ready = 1'b1;
  logic [15:0] width_out, period_out, pulse_count;
  logic        sat, meas_valid, overrun;
  logic [3:0]  w4, p4, c4;
  logic        sat4, v4, ov4;
`ifdef PULSE_METER_TIMEOUT_EN
  logic        timeout, to4;
`endif

  exp_t q[$];
  exp_t q4[$];
  int checks = 0;
  int passes = 0;
  int acc_n = 0;
  int acc4 = 0;
  int stable_err = 0;
  bit hold_on = 0;
  logic [15:0] hw, hp;
  bit open = 0;
  int prev_w = 0;
  int prev_p = 0;
  int drop_n = 0;

  always #5 clock = ~clock;

  pulse_meter #(
    .CNT_W(16),
    .SYNC_STAGES(2)
`ifdef PULSE_METER_TIMEOUT_EN
    ,
    .TIMEOUT(50)
`endif
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .enable(enable),
    .signal_in(signal_in),
    .width_out(width_out),
    .period_out(period_out),
    .sat(sat),
    .meas_valid(meas_valid),
    .meas_ready(meas_ready),
    .pulse_count(pulse_count),
    .overrun(overrun)
`ifdef PULSE_METER_TIMEOUT_EN
    ,
    .timeout(timeout)
`endif
  );

  pulse_meter #(
    .CNT_W(4),
    .SYNC_STAGES(2)
`ifdef PULSE_METER_TIMEOUT_EN
    ,
    .TIMEOUT(50)
`endif
  ) dut4 (
    .clock(clock),
    .reset_n(reset_n),
    .enable(en4),
    .signal_in(signal_in),
    .width_out(w4),
    .period_out(p4),
    .sat(sat4),
    .meas_valid(v4),
    .meas_ready(1'b1),
    .pulse_count(c4),
    .overrun(ov4)
`ifdef PULSE_METER_TIMEOUT_EN
    ,
    .timeout(to4)
`endif
  );

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act == req) passes++;
    else $display("FAIL %s: got %0d, want %0d", name, act, req);
  endtask

  // Main monitor: pop on each accepted transfer.
  always @(negedge clock) begin
    if (reset_n) begin
      if (meas_valid && meas_ready) begin
        checks++;
        if (q.size() == 0) begin
          $display("FAIL meas: unexpected w=%0d p=%0d", width_out, period_out);
        end else begin
          exp_t e;
          e = q.pop_front();
          if (width_out == 16'(e.w) && period_out == 16'(e.p) &&
              sat == e.s && pulse_count == 16'(acc_n))
            passes++;
          else
            $display("FAIL meas: got w=%0d p=%0d s=%0b c=%0d, want %0d %0d %0b %0d",
                     width_out, period_out, sat, pulse_count,
                     e.w, e.p, e.s, acc_n);
        end
        acc_n++;
      end
      if (meas_valid && !meas_ready) begin
        if (hold_on && (width_out != hw || period_out != hp)) stable_err++;
        hold_on = 1;
        hw = width_out;
        hp = period_out;
      end else begin
        hold_on = 0;
      end
    end
  end

  always @(negedge clock) begin
    if (reset_n && v4) begin
      checks++;
      if (q4.size() == 0) begin
        $display("FAIL sat4: unexpected w=%0d p=%0d", w4, p4);
      end else begin
        exp_t e;
        e = q4.pop_front();
        if (w4 == 4'(e.w) && p4 == 4'(e.p) && sat4 == e.s && c4 == 4'(acc4))
          passes++;
        else
          $display("FAIL sat4: got w=%0d p=%0d s=%0b c=%0d, want %0d %0d %0b %0d",
                   w4, p4, sat4, c4, e.w, e.p, e.s, acc4);
      end
      acc4++;
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
    prev_p += n;
  endtask

  task automatic pulse(input int hi, input int lo, input int drop_at);
    if (open) begin
      if (drop_n > 0) drop_n--;
      else q.push_back('{prev_w, prev_p, 1'b0});
    end
    open = 1;
    signal_in = 1'b1;
    for (int i = 0; i < hi; i++) begin
      if (drop_at != 0 && i == drop_at) begin
        enable = 1'b0;
        open = 0;
      end
      if (drop_at != 0 && i == drop_at + 1) enable = 1'b1;
      step();
    end
    signal_in = 1'b0;
    repeat (lo) step();
    prev_w = hi;
    prev_p = hi + lo;
  endtask

  initial begin
    repeat (3) step();
    check("reset_state", {width_out, period_out, pulse_count,
                          sat, meas_valid, overrun} == '0, 1);
    reset_n = 1'b1;
    enable = 1'b1;
    idle(4);

    // Clean periodic input
    repeat (4) pulse(5, 7, 0);
    check("no_overrun", overrun, 0);

    // Backpressure
    meas_ready = 1'b0;
    pulse(5, 7, 0);
    drop_n = 2;
    pulse(5, 7, 0);
    pulse(5, 7, 0);
    check("held_valid", meas_valid, 1);
    check("overrun_set", overrun, 1);
    check("held_stable", stable_err, 0);
    check("count_held", pulse_count, acc_n);
    meas_ready = 1'b1;
    pulse(5, 7, 0);
    pulse(5, 7, 0);

    // Enable drop during HIGH, re-enable mid-pulse
    pulse(5, 7, 3);
    pulse(5, 7, 0);
    pulse(5, 7, 0);
    pulse(5, 7, 0);

    // Saturation on the 4-bit instance
    en4 = 1'b1;
    idle(2);
    pulse(20, 3, 0);
    q4.push_back('{15, 15, 1'b1});
    pulse(20, 3, 0);
    q4.push_back('{15, 15, 1'b1});
    pulse(20, 3, 0);
    en4 = 1'b0;
    pulse(5, 7, 0);

    // Reset mid-pulse
    if (open) q.push_back('{prev_w, prev_p, 1'b0});
    signal_in = 1'b1;
    repeat (4) step();
    #2 reset_n = 1'b0;
    #1;
    check("reset_async", {width_out, period_out, pulse_count,
                          sat, meas_valid, overrun} == '0, 1);
    check("reset_drained", q.size(), 0);
    signal_in = 1'b0;
    acc_n = 0;
    acc4 = 0;
    open = 0;
    repeat (3) step();
    reset_n = 1'b1;
    idle(4);
    repeat (3) pulse(5, 7, 0);

`ifdef PULSE_METER_TIMEOUT_EN
    check("timeout_clear", timeout, 0);
    pulse(60, 7, 0);
    open = 0;
    check("timeout_set", timeout, 1);
    pulse(5, 7, 0);
    pulse(5, 7, 0);
`endif

    idle(10);
    check("drain_main", q.size(), 0);
    check("drain_sat4", q4.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/pulse_meter.md
Name: pulse_meter

Overview:
- Downstream consumer of the pulse/trigger generators' `signal` output.
- Synchronises an asynchronous pulse input, detects its edges, and measures high-time (width) and rise-to-rise time (period) in clock cycles.
- Counts completed pulses.
- Publishes each measurement through a valid/ready handshake to a logger or checker stage.

Parameters:
- CNT_W, 16, width of the width/period counters and pulse_count.
- SYNC_STAGES, 2, number of flip-flops in the input synchroniser (minimum 2).
- TIMEOUT, 1000, idle-cycle limit used only when PULSE_METER_TIMEOUT_EN is defined.

Ports:
- clock  input  1  system clock; all state on its rising edge.
- reset_n  input  1  asynchronous active-low reset.
- enable  input  1  1 = measure; 0 = return to IDLE, counters cleared.
- signal_in  input  1  asynchronous pulse to measure.
- width_out  output  CNT_W  high-time of last completed measurement.
- period_out  output  CNT_W  rise-to-rise time of last completed measurement.
- sat  output  1  width_out or period_out saturated in this measurement.
- meas_valid  output  1  measurement available.
- meas_ready  input  1  consumer accepts measurement.
- pulse_count  output  CNT_W  completed measurements accepted, saturating.
- overrun  output  1  sticky: a measurement was dropped while output was held.

Behaviour:
- Reset (asynchronous, reset_n = 0):
  - All outputs 0; synchroniser and edge register 0; FSM in IDLE.
- Synchroniser and edge detection:
  - s = signal_in after SYNC_STAGES flops; s_d = s delayed one cycle.
  - rise = s & ~s_d; fall = ~s & s_d.
  - Latency from signal_in to rise/fall is SYNC_STAGES + 1 cycles.
- FSM states: IDLE, ARM, HIGH, LOW.
  - IDLE: when enable = 1, go to ARM (ARM discards any pulse already in progress).
  - ARM: on rise, clear width_cnt and period_cnt to 1, go to HIGH.
  - HIGH: width_cnt++ and period_cnt++ each cycle; on fall, freeze width_cnt and go to LOW.
  - LOW: period_cnt++ each cycle; on rise, complete the measurement, reload both counters to 1, go to HIGH.
  - Consecutive periods are measured back to back; each rise both closes one period and opens the next.
- Counting rules:
  - width = cycles from rise detect to fall detect.
  - period = cycles from rise detect to next rise detect.
  - Counters saturate at 2^CNT_W-1 and do not wrap; saturation sets the sat bit for that measurement.
- Completion:
  - If meas_valid = 0, or meas_valid & meas_ready in the same cycle: width_out, period_out and sat load next cycle, and meas_valid = 1 next cycle.
  - Otherwise the held result stays unchanged, the new measurement is dropped, and overrun sets (cleared only by reset).
- Handshake:
  - meas_valid and outputs are stable until meas_ready = 1 is sampled; meas_valid then falls next cycle unless a completion reloads it in the same cycle.
  - pulse_count increments on each accepted transfer (meas_valid & meas_ready), saturating.
- enable deasserted mid-measurement:
  - Next state IDLE; counters cleared; a pending meas_valid is kept until it is accepted.
- Simultaneous rise and fall cannot occur (single s_d source).
- A pulse narrower than one clock may be missed. This is accepted behaviour.

Optional Feature:
- Macro: PULSE_METER_TIMEOUT_EN.
- Defined:
  - A separate idle counter runs in HIGH and LOW and resets on every edge.
  - Reaching TIMEOUT forces the FSM to ARM, discards the partial measurement, and sets a sticky output `timeout` (1 bit, reset 0).
  - The port is present only under the macro.
- Undefined:
  - No idle counter and no `timeout` port.
  - A stuck input leaves the FSM in HIGH/LOW with counters saturated.

Decomposition:
- Shared package pulse_meter_pkg: FSM state enum (IDLE, ARM, HIGH, LOW, 2-bit encoding) and default CNT_W and SYNC_STAGES constants.
- One natural sub-module: sync_edge_detect (SYNC_STAGES parameter; outputs s, rise, fall), reusable by other consumers of the pulse/trigger outputs.

Test Plan:
- Reset mid-run:
  - Stimulus: drive reset_n low asynchronously mid-pulse.
  - Response: all outputs 0 within the same cycle; after release and enable, first completion only after a fresh rise.
- Clean periodic input:
  - Stimulus: signal_in high 5 cycles, low 7 cycles, repeating; meas_ready = 1.
  - Response: every completion gives width_out = 5, period_out = 12, sat = 0; pulse_count increments 1, 2, 3.
- Backpressure:
  - Stimulus: same input as above; meas_ready = 0 for 30 cycles.
  - Response: first result held stable; overrun = 1 after the second completion; on release, pulse_count += 1 only.
- Saturation:
  - Stimulus: CNT_W = 4, high 20 cycles, low 3 cycles.
  - Response: width_out = 15, period_out = 15, sat = 1; no wrap.
- Enable drop:
  - Stimulus: enable = 0 during HIGH, then back to 1 mid-pulse.
  - Response: no completion until one full rise-to-rise after re-arm.
- Timeout (PULSE_METER_TIMEOUT_EN defined):
  - Stimulus: TIMEOUT = 50, signal_in held high for 60 cycles.
  - Response: timeout = 1 at idle count 50; no meas_valid from that pulse.
